gpo_reg_bank: RTL and testbench

//  Bank of 16 x 8-bit general-purpose output registers. Both I2C slave ports
//  (port 1, port 2) can write and read it back. Each register is selected
//  one-hot by OFFSET_SEL. This is the write-side counterpart of the GPI bank.

---
 rtl/gpo_reg_bank.sv | 97 +++++++++
 tb/tb_gpo_reg_bank.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpo_reg_bank.sv
// gpo_reg_bank: 16 x 8-bit output registers shared by two slave ports. It provides
// per-register write strobes, port-1-priority collision handling and self-clearing pulse registers.
module gpo_reg_bank #(
  parameter logic [7:0]  RESET_VALUE = 8'h00,
  parameter logic [15:0] PULSE_MASK  = 16'h0000,
  parameter int          PULSE_LEN   = 4
) (
  input  logic         SYSCLK,
  input  logic         RESET_N,
  input  logic         PORT_CS1,
  input  logic [15:0]  OFFSET_SEL1,
  input  logic         RD_WR1,
  input  logic [7:0]   DIN1,
  input  logic         PORT_CS2,
  input  logic [15:0]  OFFSET_SEL2,
  input  logic         RD_WR2,
  input  logic [7:0]   DIN2,
  output logic [7:0]   DOUT1,
  output logic [7:0]   DOUT2,
  output logic [127:0] GPO_Q,
  output logic [15:0]  WR_STB,
  output logic         COLLISION
);

  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_LEN);

  logic        wq1, wq2;
  logic        wr1, wr2;
  logic        wq1_d_reg, wq2_d_reg;
  logic        armed1_reg, armed2_reg;
  logic [15:0] wsel1, wsel2;
  logic [7:0]  rd1, rd2;

  assign wq1 = PORT_CS1 & ~RD_WR1;
  assign wq2 = PORT_CS2 & ~RD_WR2;

  // A port must show its write qualifier low at least once after reset before it can
  // fire, so a select that was still held through reset does not produce a write.
  assign wr1 = wq1 & ~wq1_d_reg & armed1_reg;
  assign wr2 = wq2 & ~wq2_d_reg & armed2_reg;

  assign wsel1 = wr1 ? OFFSET_SEL1 : 16'h0000;
  assign wsel2 = wr2 ? OFFSET_SEL2 : 16'h0000;

  always_comb begin
    rd1 = 8'h00;
    rd2 = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (OFFSET_SEL1[i]) rd1 = rd1 | GPO_Q[8*i +: 8];
      if (OFFSET_SEL2[i]) rd2 = rd2 | GPO_Q[8*i +: 8];
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wq1_d_reg  <= 1'b0;
      wq2_d_reg  <= 1'b0;
      armed1_reg <= 1'b0;
      armed2_reg <= 1'b0;
      WR_STB     <= 16'h0000;
      COLLISION  <= 1'b0;
      DOUT1      <= 8'h00;
      DOUT2      <= 8'h00;
    end else begin
      wq1_d_reg  <= wq1;
      wq2_d_reg  <= wq2;
      armed1_reg <= armed1_reg | ~wq1;
      armed2_reg <= armed2_reg | ~wq2;
      WR_STB     <= wsel1 | wsel2;
      COLLISION  <= |(wsel1 & wsel2);
      if (PORT_CS1 & RD_WR1) DOUT1 <= rd1;
      if (PORT_CS2 & RD_WR2) DOUT2 <= rd2;
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_reg
    logic [7:0] val_reg;
    logic [3:0] cnt_reg;

    // A write always beats a pulse expiring on the same edge.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
      if (!RESET_N) begin
        val_reg <= RESET_VALUE;
        cnt_reg <= 4'd0;
      end else if (wsel1[gi] || wsel2[gi]) begin
        val_reg <= wsel1[gi] ? DIN1 : DIN2;
        cnt_reg <= PULSE_MASK[gi] ? PULSE_LOAD : 4'd0;
      end else if (PULSE_MASK[gi] && (cnt_reg != 4'd0)) begin
        cnt_reg <= cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) val_reg <= RESET_VALUE;
      end
    end

    assign GPO_Q[8*gi +: 8] = val_reg;
  end

endmodule

// File: tb/tb_gpo_reg_bank.sv
// Bench for gpo_reg_bank: directed and random port traffic, a reference model that
// queues the expected outputs, and a monitor that pops and compares them every cycle.
module tb_gpo_reg_bank;

  localparam logic [7:0]  RV    = 8'h5A;
  localparam logic [15:0] PMASK = 16'h0401;
  localparam int          PLEN  = 4;

  logic         SYSCLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         PORT_CS1 = 1'b0, RD_WR1 = 1'b0, PORT_CS2 = 1'b0, RD_WR2 = 1'b0;
  logic [15:0]  OFFSET_SEL1 = '0, OFFSET_SEL2 = '0;
  logic [7:0]   DIN1 = '0, DIN2 = '0;
  logic [7:0]   DOUT1, DOUT2;
  logic [127:0] GPO_Q;
  logic [15:0]  WR_STB;
  logic         COLLISION;

  always #5 SYSCLK = ~SYSCLK;

  gpo_reg_bank #(.RESET_VALUE(RV), .PULSE_MASK(PMASK), .PULSE_LEN(PLEN)) dut (
    .SYSCLK(SYSCLK), .RESET_N(RESET_N),
    .PORT_CS1(PORT_CS1), .OFFSET_SEL1(OFFSET_SEL1), .RD_WR1(RD_WR1), .DIN1(DIN1),
    .PORT_CS2(PORT_CS2), .OFFSET_SEL2(OFFSET_SEL2), .RD_WR2(RD_WR2), .DIN2(DIN2),
    .DOUT1(DOUT1), .DOUT2(DOUT2), .GPO_Q(GPO_Q), .WR_STB(WR_STB), .COLLISION(COLLISION)
  );

  typedef struct {
    logic [127:0] gpo;
    logic [15:0]  stb;
    logic         coll;
    logic [7:0]   d1;
    logic [7:0]   d2;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference state: register values, cycles of pulse visibility left, and whether
  // each port's write qualifier was high last cycle (treated as high right after reset).
  logic [7:0] m_mem [16];
  int         m_left [16];
  bit         m_last1, m_last2;
  logic [7:0] m_d1, m_d2;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i]  = RV;
      m_left[i] = 0;
    end
    m_last1 = 1'b1;
    m_last2 = 1'b1;
    m_d1 = 8'h00;
    m_d2 = 8'h00;
  endtask

  task automatic model_step();
    exp_t        e;
    logic [7:0]  rd;
    logic [15:0] w1, w2;
    bit          wq1, wq2;
    wq1 = PORT_CS1 && !RD_WR1;
    wq2 = PORT_CS2 && !RD_WR2;
    w1 = (wq1 && !m_last1) ? OFFSET_SEL1 : 16'h0000;
    w2 = (wq2 && !m_last2) ? OFFSET_SEL2 : 16'h0000;
    m_last1 = wq1;
    m_last2 = wq2;
    if (PORT_CS1 && RD_WR1) begin
      rd = 8'h00;
      for (int i = 0; i < 16; i++) if (OFFSET_SEL1[i]) rd = rd | m_mem[i];
      m_d1 = rd;
    end
    if (PORT_CS2 && RD_WR2) begin
      rd = 8'h00;
      for (int i = 0; i < 16; i++) if (OFFSET_SEL2[i]) rd = rd | m_mem[i];
      m_d2 = rd;
    end
    for (int i = 0; i < 16; i++) begin
      if (m_left[i] > 0) begin
        m_left[i]--;
        if (m_left[i] == 0) m_mem[i] = RV;
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (w2[i]) begin m_mem[i] = DIN2; m_left[i] = PMASK[i] ? PLEN : 0; end
    end
    for (int i = 0; i < 16; i++) begin
      if (w1[i]) begin m_mem[i] = DIN1; m_left[i] = PMASK[i] ? PLEN : 0; end
    end
    e.stb  = w1 | w2;
    e.coll = |(w1 & w2);
    e.d1   = m_d1;
    e.d2   = m_d2;
    for (int i = 0; i < 16; i++) e.gpo[8*i +: 8] = m_mem[i];
    sb_q.push_back(e);
  endtask

  // Called at a falling edge with inputs already set; releases reset if it was held.
  task automatic tick();
    RESET_N = 1'b1;
    model_step();
    @(negedge SYSCLK);
  endtask

  task automatic p1(input logic cs, input logic rw, input logic [15:0] sel, input logic [7:0] din);
    PORT_CS1 = cs; RD_WR1 = rw; OFFSET_SEL1 = sel; DIN1 = din;
  endtask

  task automatic p2(input logic cs, input logic rw, input logic [15:0] sel, input logic [7:0] din);
    PORT_CS2 = cs; RD_WR2 = rw; OFFSET_SEL2 = sel; DIN2 = din;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_gpo"}, GPO_Q, {16{RV}});
    chk({tag, "_dout1"}, 128'(DOUT1), 128'h0);
    chk({tag, "_dout2"}, 128'(DOUT2), 128'h0);
    chk({tag, "_stb"}, 128'(WR_STB), 128'h0);
    chk({tag, "_coll"}, 128'(COLLISION), 128'h0);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    model_reset();
    #1;
    check_reset_state("async_reset");
    @(negedge SYSCLK);
  endtask

  function automatic logic [15:0] rand_sel();
    case ($urandom_range(0, 3))
      0:       rand_sel = 16'h0000;
      3:       rand_sel = 16'($urandom);
      default: rand_sel = 16'h0001 << $urandom_range(0, 15);
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge SYSCLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("gpo_q", GPO_Q, e.gpo);
        chk("wr_stb", 128'(WR_STB), 128'(e.stb));
        chk("collision", 128'(COLLISION), 128'(e.coll));
        chk("dout1", 128'(DOUT1), 128'(e.d1));
        chk("dout2", 128'(DOUT2), 128'(e.d2));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] s;
    model_reset();
    repeat (3) @(negedge SYSCLK);
    #1;
    check_reset_state("power_on_reset");
    @(negedge SYSCLK);
    tick();                                   // release reset, both ports idle

    // single port-1 write held for five cycles, then readback on port 2
    p1(1, 0, 16'h0008, 8'hC3);
    repeat (5) tick();
    p1(0, 0, 16'h0000, 8'h00); tick();
    p2(1, 1, 16'h0008, 8'h00); tick();
    p2(0, 0, 16'h0000, 8'h00); tick();

    // same-register collision, then different registers
    p1(1, 0, 16'h0080, 8'h11); p2(1, 0, 16'h0080, 8'h22); tick();
    p1(0, 0, 16'h0000, 8'h00); p2(0, 0, 16'h0000, 8'h00); tick();
    p1(1, 0, 16'h0080, 8'h11); p2(1, 0, 16'h0100, 8'h22); tick();
    p1(0, 0, 16'h0000, 8'h00); p2(0, 0, 16'h0000, 8'h00); tick();

    // pulse register 0: write, rewrite two cycles later, let it expire
    p1(1, 0, 16'h0001, 8'h01); tick();
    p1(0, 0, 16'h0000, 8'h00); repeat (2) tick();
    p1(1, 0, 16'h0001, 8'h02); tick();
    p1(0, 0, 16'h0000, 8'h00); repeat (6) tick();

    // reset mid-pulse with port 1 still selecting a write
    p1(1, 0, 16'h0001, 8'h33); tick();
    tick();
    do_reset();
    repeat (3) tick();                        // CS held high: no write expected
    p1(0, 0, 16'h0001, 8'h33); tick();
    p1(1, 0, 16'h0001, 8'h44); tick();
    p1(0, 0, 16'h0000, 8'h00); tick();

    // read in the same cycle as a write returns the old value
    p1(1, 0, 16'h0020, 8'hAA); p2(1, 1, 16'h0020, 8'h00); tick();
    p1(0, 0, 16'h0000, 8'h00); tick();
    p2(1, 1, 16'h0000, 8'h00); tick();        // empty select reads 00
    p2(0, 0, 16'h0000, 8'h00); tick();

    // random traffic including collisions, multi-select and pulse registers
    for (int n = 0; n < 400; n++) begin
      s = rand_sel();
      p1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), s, 8'($urandom));
      p2(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
         ($urandom_range(0, 3) == 0) ? s : rand_sel(), 8'($urandom));
      tick();
      if (n == 200) do_reset();
    end
    p1(0, 0, 16'h0000, 8'h00); p2(0, 0, 16'h0000, 8'h00);
    repeat (6) tick();

    @(posedge SYSCLK);
    #2;
    chk("queue_drained", 128'(sb_q.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
